// File: rtl/div_unit_pkg.sv
// Shared constants for the EX-stage divider: state encoding, widths, handshake levels.
// No logic; imported by div_unit.
// The stall and ready levels match the pipeline_ctrl stall convention.
package div_unit_pkg;

   localparam int DIV_DATA_W = 32;
   localparam int DIV_CNT_W  = 6;

   typedef enum logic [1:0] {
      DIV_FREE   = 2'b00,
      DIV_BYZERO = 2'b01,
      DIV_ON     = 2'b10,
      DIV_END    = 2'b11
   } div_state_t;

   localparam logic DIV_RESULT_READY     = 1'b1;
   localparam logic DIV_RESULT_NOT_READY = 1'b0;

   localparam logic DIV_CMD_START = 1'b1;

   localparam logic STALL_STOP    = 1'b1;
   localparam logic STALL_NO_STOP = 1'b0;

endpackage

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider (DIV/DIVU) that stalls the pipeline until its result is ready.
// Latency: 33 cycles from start for a non-zero divisor, 2 cycles for a zero divisor.
// Backpressure: result is held in END while start_i stays high; stallreq_o is high while waiting.
module div_unit
   import div_unit_pkg::*;
#(
   parameter int DATA_W = DIV_DATA_W,
   parameter int CNT_W  = DIV_CNT_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start_i,
   input  logic                annul_i,
   input  logic                signed_i,
   input  logic [DATA_W-1:0]   opdata1_i,
   input  logic [DATA_W-1:0]   opdata2_i,
   output logic [2*DATA_W-1:0] result_o,
   output logic                ready_o,
   output logic                stallreq_o
);

   div_state_t          state;
   div_state_t          state_nxt;
   logic [CNT_W-1:0]    cnt;
   logic [2*DATA_W:0]   work;
   logic [2*DATA_W:0]   work_step;
   logic [DATA_W-1:0]   dvsr;
   logic [DATA_W:0]     diff;
   logic                neg_q;
   logic                neg_r;
   logic                last_step;
   logic                go;
   logic [DATA_W-1:0]   op1_abs;
   logic [DATA_W-1:0]   op2_abs;
   logic [DATA_W-1:0]   q_fix;
   logic [DATA_W-1:0]   r_fix;
   logic [2*DATA_W-1:0] result;
   logic                ready;

   // A request is accepted only when it is not being flushed in the same cycle.
   assign go = (start_i == DIV_CMD_START) && !annul_i;

   // Magnitudes for DIV; the most negative value negates to itself, which the unsigned core handles.
   always_comb begin
      op1_abs = opdata1_i;
      op2_abs = opdata2_i;
      if (signed_i && opdata1_i[DATA_W-1]) op1_abs = -opdata1_i;
      if (signed_i && opdata2_i[DATA_W-1]) op2_abs = -opdata2_i;
   end

   // One restoring step: trial-subtract the divisor from the upper half and shift in the quotient bit.
   always_comb begin
      diff = {1'b0, work[2*DATA_W-1:DATA_W]} - {1'b0, dvsr};
      if (diff[DATA_W]) begin
         work_step = {work[2*DATA_W-1:0], 1'b0};
      end else begin
         work_step = {diff[DATA_W-1:0], work[DATA_W-1:0], 1'b1};
      end
      last_step = (cnt == CNT_W'(DATA_W - 1));
      q_fix = work_step[DATA_W-1:0];
      r_fix = work_step[2*DATA_W:DATA_W+1];
      if (neg_q) q_fix = -work_step[DATA_W-1:0];
      if (neg_r) r_fix = -work_step[2*DATA_W:DATA_W+1];
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= DIV_FREE;
      else     state <= state_nxt;
   end

   // Next-state: flush wins in BYZERO/ON, start_i alone releases END.
   always_comb begin
      state_nxt = state;
      case (state)
         DIV_FREE: begin
            if (go) state_nxt = (opdata2_i == '0) ? DIV_BYZERO : DIV_ON;
         end
         DIV_BYZERO: begin
            state_nxt = annul_i ? DIV_FREE : DIV_END;
         end
         DIV_ON: begin
            if (annul_i)        state_nxt = DIV_FREE;
            else if (last_step) state_nxt = DIV_END;
         end
         DIV_END: begin
            if (start_i != DIV_CMD_START) state_nxt = DIV_FREE;
         end
         default: state_nxt = DIV_FREE;
      endcase
   end

   // Datapath: operand capture, iteration, result/ready registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt    <= '0;
         work   <= '0;
         dvsr   <= '0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         result <= '0;
         ready  <= DIV_RESULT_NOT_READY;
      end else begin
         case (state)
            DIV_FREE: begin
               result <= '0;
               ready  <= DIV_RESULT_NOT_READY;
               if (go) begin
                  cnt   <= '0;
                  work  <= {{DATA_W{1'b0}}, op1_abs, 1'b0};
                  dvsr  <= op2_abs;
                  neg_q <= signed_i && (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                  neg_r <= signed_i && opdata1_i[DATA_W-1];
               end
            end
            DIV_BYZERO: begin
               result <= '0;
               ready  <= annul_i ? DIV_RESULT_NOT_READY : DIV_RESULT_READY;
            end
            DIV_ON: begin
               if (annul_i) begin
                  result <= '0;
                  ready  <= DIV_RESULT_NOT_READY;
               end else begin
                  work <= work_step;
                  cnt  <= cnt + CNT_W'(1);
                  if (last_step) begin
                     result <= {r_fix, q_fix};
                     ready  <= DIV_RESULT_READY;
                  end
               end
            end
            DIV_END: begin
               if (start_i != DIV_CMD_START) begin
                  result <= '0;
                  ready  <= DIV_RESULT_NOT_READY;
               end
            end
            default: begin
               result <= '0;
               ready  <= DIV_RESULT_NOT_READY;
            end
         endcase
      end
   end

   assign result_o   = result;
   assign ready_o    = ready;
   assign stallreq_o = (!rst && start_i && !ready && !annul_i) ? STALL_STOP : STALL_NO_STOP;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: quotient/remainder values, latency, stall window, flush and reset.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Ends with a one-line error/check summary.
module tb_div_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_i;
   logic        annul_i;
   logic        signed_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic [63:0] result_o;
   logic        ready_o;
   logic        stallreq_o;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   div_unit dut (
      .clk        (clk),
      .rst        (rst),
      .start_i    (start_i),
      .annul_i    (annul_i),
      .signed_i   (signed_i),
      .opdata1_i  (opdata1_i),
      .opdata2_i  (opdata2_i),
      .result_o   (result_o),
      .ready_o    (ready_o),
      .stallreq_o (stallreq_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Entered just after a rising edge with the DUT in FREE; leaves it the same way.
   task automatic do_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp,
                         input int exp_cyc, input int hold);
      int   cyc;
      int   stalls;
      logic got;
      start_i   = 1'b1;
      annul_i   = 1'b0;
      signed_i  = sgn;
      opdata1_i = a;
      opdata2_i = b;
      cyc    = 0;
      stalls = 0;
      got    = 1'b0;
      while (!got && cyc < 40) begin
         @(negedge clk);
         if (ready_o === 1'b1) begin
            got = 1'b1;
         end else begin
            if (stallreq_o === 1'b1) stalls++;
            @(posedge clk);
            #1;
            cyc++;
            // Operands are scrambled after capture; they must not matter.
            opdata1_i = $urandom;
            opdata2_i = $urandom;
            signed_i  = ~sgn;
         end
      end
      chk({tag, " ready_cycle"}, 64'(cyc), 64'(exp_cyc));
      chk({tag, " stall_cycles"}, 64'(stalls), 64'(exp_cyc));
      chk({tag, " result"}, result_o, exp);
      chk({tag, " stall_when_ready"}, 64'(stallreq_o), 64'd0);
      if (hold > 0) begin
         // Flush in END must be ignored while start_i is still high.
         annul_i = 1'b1;
         repeat (hold) @(negedge clk);
         chk({tag, " held_result"}, result_o, exp);
         chk({tag, " held_ready"}, 64'(ready_o), 64'd1);
      end
      start_i = 1'b0;
      annul_i = 1'b0;
      @(posedge clk);
      #1;
      chk({tag, " cleared_ready"}, 64'(ready_o), 64'd0);
      chk({tag, " cleared_result"}, result_o, 64'd0);
   endtask

   initial begin
      logic seen;
      rst       = 1'b1;
      start_i   = 1'b1;
      annul_i   = 1'b0;
      signed_i  = 1'b0;
      opdata1_i = 32'd5;
      opdata2_i = 32'd3;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset stallreq", 64'(stallreq_o), 64'd0);
      chk("reset ready", 64'(ready_o), 64'd0);
      chk("reset result", result_o, 64'd0);
      @(posedge clk);
      #1;
      rst     = 1'b0;
      start_i = 1'b0;
      chk("post_reset ready", 64'(ready_o), 64'd0);

      do_div("divu_100_7",   1'b0, 32'd100,       32'd7,         64'h00000002_0000000E, 33, 5);
      do_div("div_m7_2",     1'b1, 32'hFFFFFFF9,  32'd2,         64'hFFFFFFFF_FFFFFFFD, 33, 0);
      do_div("div_7_m2",     1'b1, 32'd7,         32'hFFFFFFFE,  64'h00000001_FFFFFFFD, 33, 0);
      do_div("divu_by_zero", 1'b0, 32'd1234,      32'd0,         64'd0,                 2,  0);
      do_div("div_by_zero",  1'b1, 32'hFFFFFFF0,  32'd0,         64'd0,                 2,  0);
      do_div("div_min_m1",   1'b1, 32'h80000000,  32'hFFFFFFFF,  64'h00000000_80000000, 33, 0);
      do_div("divu_max_1",   1'b0, 32'hFFFFFFFF,  32'd1,         64'h00000000_FFFFFFFF, 33, 0);
      do_div("divu_min_max", 1'b0, 32'h80000000,  32'hFFFFFFFF,  64'h80000000_00000000, 33, 0);
      do_div("div_m100_m7",  1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9,  64'hFFFFFFFE_0000000E, 33, 0);
      do_div("divu_beef_16", 1'b0, 32'hDEADBEEF,  32'h00000010,  64'h0000000F_0DEADBEE, 33, 0);

      // Flush at cycle 10.
      start_i   = 1'b1;
      signed_i  = 1'b0;
      opdata1_i = 32'd1000;
      opdata2_i = 32'd3;
      repeat (10) @(posedge clk);
      #1;
      annul_i = 1'b1;
      @(negedge clk);
      chk("annul stallreq", 64'(stallreq_o), 64'd0);
      @(posedge clk);
      #1;
      start_i = 1'b0;
      annul_i = 1'b0;
      chk("annul ready", 64'(ready_o), 64'd0);
      chk("annul result", result_o, 64'd0);
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (ready_o !== 1'b0) seen = 1'b1;
      end
      chk("annul never_ready", 64'(seen), 64'd0);
      @(posedge clk);
      #1;

      // Reset at cycle 15.
      start_i   = 1'b1;
      signed_i  = 1'b1;
      opdata1_i = 32'hFFFF0000;
      opdata2_i = 32'd9;
      repeat (15) @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      chk("midrst stallreq", 64'(stallreq_o), 64'd0);
      @(posedge clk);
      #1;
      rst     = 1'b0;
      start_i = 1'b0;
      chk("midrst ready", 64'(ready_o), 64'd0);
      chk("midrst result", result_o, 64'd0);
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (ready_o !== 1'b0) seen = 1'b1;
      end
      chk("midrst never_ready", 64'(seen), 64'd0);
      @(posedge clk);
      #1;

      do_div("after_rst_100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
